// File: rtl/urate_bitstream_decoder.sv
// urate_bitstream_decoder
// Receive end of the unary-rate link: counts ones over a window of
// 2^winQ enabled samples and returns the ones rate as a WIDTH-bit
// fraction (result/2^WIDTH == ones rate). Results wait behind a
// valid/ready handshake until the consumer takes them.
module urate_bitstream_decoder #(
   parameter int WIDTH    = 16,
   parameter int LOGWIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LOGWIDTH:0]   winLog,
   input  logic                enable,
   input  logic                bitIn,
   output logic                busy,
   output logic                resValid,
   input  logic                resReady,
   output logic [WIDTH-1:0]    result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [LOGWIDTH:0] WIN_MAX = (LOGWIDTH+1)'(WIDTH);
   localparam logic [WIDTH:0]    ONE_W   = (WIDTH+1)'(1);

   state_t              state_reg;
   state_t              state_next;
   logic [LOGWIDTH:0]   win_q_reg;
   logic [WIDTH:0]      bit_cnt_reg;
   logic [WIDTH:0]      ones_cnt_reg;
   logic [WIDTH-1:0]    result_reg;

   logic [LOGWIDTH:0]   win_clamped;
   logic [LOGWIDTH:0]   shift_amt;
   logic [WIDTH:0]      win_len;
   logic [WIDTH:0]      ones_final;
   logic [WIDTH:0]      shifted;
   logic [WIDTH-1:0]    result_sat;
   logic                load;
   logic                last_sample;

   // Window lengths beyond the fraction width are meaningless; clamp them.
   assign win_clamped = (winLog > WIN_MAX) ? WIN_MAX : winLog;

   // A new window starts from IDLE or RUN on start, and from DONE only
   // when the pending result is taken on the same edge.
   assign load = start && ((state_reg != S_DONE) || resReady);

   assign win_len     = ONE_W << win_q_reg;
   assign ones_final  = ones_cnt_reg + {{WIDTH{1'b0}}, bitIn};
   assign last_sample = (state_reg == S_RUN) && !start && enable &&
                        ((bit_cnt_reg + ONE_W) == win_len);

   // Scale the ones count up to WIDTH fraction bits; the count never
   // exceeds the window length, so the shift cannot lose bits.
   assign shift_amt = WIN_MAX - win_q_reg;
   assign shifted   = ones_final << shift_amt;

   // Only an all-ones window reaches 2^WIDTH; its low bits are then zero,
   // so OR-ing in the overflow bit yields 2^WIDTH-1.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sat
         assign result_sat[gi] = shifted[gi] | shifted[WIDTH];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: start always (re)opens a window, except in DONE
   // where it needs the result to be accepted in the same cycle.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_RUN;
         end
         S_RUN: begin
            if (start)            state_next = S_RUN;
            else if (last_sample) state_next = S_DONE;
         end
         S_DONE: begin
            if (resReady) state_next = start ? S_RUN : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode: busy while counting, valid while a result is held.
   always_comb begin
      busy     = (state_reg == S_RUN);
      resValid = (state_reg == S_DONE);
      result   = result_reg;
   end

   // Datapath: capture the window on load, count enabled samples in RUN,
   // latch the scaled fraction on the final sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q_reg    <= '0;
         bit_cnt_reg  <= '0;
         ones_cnt_reg <= '0;
         result_reg   <= '0;
      end else if (load) begin
         win_q_reg    <= win_clamped;
         bit_cnt_reg  <= '0;
         ones_cnt_reg <= '0;
      end else if ((state_reg == S_RUN) && enable) begin
         bit_cnt_reg  <= bit_cnt_reg + ONE_W;
         ones_cnt_reg <= ones_final;
         if (last_sample) begin
            result_reg <= result_sat;
         end
      end
   end

endmodule

// File: tb/tb_urate_bitstream_decoder.sv
// Bench for urate_bitstream_decoder: expected fractions are queued when a
// window is driven and compared when the DUT hands a result over.
module tb_urate_bitstream_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  winLog;
   logic        enable;
   logic        bitIn;
   logic        busy;
   logic        resValid;
   logic        resReady;
   logic [15:0] result;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pushed = 0;
   int          n_seen   = 0;
   logic [15:0] sb_q[$];

   urate_bitstream_decoder #(.WIDTH(16), .LOGWIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .winLog   (winLog),
      .enable   (enable),
      .bitIn    (bitIn),
      .busy     (busy),
      .resValid (resValid),
      .resReady (resReady),
      .result   (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input logic [15:0] v);
      sb_q.push_back(v);
      n_pushed++;
   endtask

   // Start cycle drives a live sample that must not be counted.
   task automatic do_start(input logic [4:0] wl);
      start  = 1'b1;
      winLog = wl;
      enable = 1'b1;
      bitIn  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic send(input logic en, input logic b);
      enable = en;
      bitIn  = b;
      tick();
   endtask

   function automatic logic pat(input int mode, input int i);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (i % 2) == 0;
         default: return (i % 4) == 0;
      endcase
   endfunction

   task automatic run_win(input string tag, input logic [4:0] wl, input int n,
                          input int mode, input logic [15:0] exp);
      expect_res(exp);
      do_start(wl);
      for (int i = 0; i < n; i++) send(1'b1, pat(mode, i));
      check({tag, "_valid"}, resValid, 1'b1);
      enable = 1'b0;
      tick();
   endtask

   // Scoreboard side: a handshake completes on the coming edge.
   always @(negedge clk) begin : mon
      logic [15:0] e;
      if (rst_n === 1'b1 && resValid === 1'b1 && resReady === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            n_seen++;
            $display("txn %0d result=0x%04h exp=0x%04h", n_seen, result, e);
            check("result", {16'h0, result}, {16'h0, e});
         end
      end
   end

   initial begin : stim
      logic [7:0]  en_bits;
      logic [15:0] s;
      int          cnt;
      int          guard;
      int          tz;

      rst_n = 1'b0; start = 1'b0; enable = 1'b0; bitIn = 1'b0;
      resReady = 1'b1; winLog = 5'd0;
      tick(); tick();
      check("rst_busy",   busy,     1'b0);
      check("rst_valid",  resValid, 1'b0);
      check("rst_result", {16'h0, result}, 32'h0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", busy, 1'b0);

      // Alternating 1,0 over 16 samples; winLog change after start is ignored.
      expect_res(16'h8000);
      do_start(5'd4);
      winLog = 5'd0;
      check("alt_busy", busy, 1'b1);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            check("alt_valid_early", resValid, 1'b0);
            check("alt_busy_early",  busy,     1'b1);
         end
         send(1'b1, pat(2, i));
      end
      check("alt_valid", resValid, 1'b1);
      check("alt_busy_done", busy, 1'b0);
      enable = 1'b0;
      tick();
      check("alt_accepted", resValid, 1'b0);
      check("alt_hold", {16'h0, result}, 32'h8000);

      // Saturation, zero, single-sample and clamped windows.
      run_win("all1",  5'd4,  16,    1, 16'hFFFF);
      run_win("all0",  5'd4,  16,    0, 16'h0000);
      run_win("wl0",   5'd0,  1,     1, 16'hFFFF);
      run_win("wl20",  5'd20, 65536, 4, 16'h4000);

      // Enable gaps with ones on disabled cycles.
      en_bits = 8'b1101_1011;
      expect_res(16'hC000);
      do_start(5'd3);
      for (int c = 0; c < 16; c++) begin
         if (c % 2 == 0) send(1'b1, en_bits[c/2]);
         else            send(1'b0, 1'b1);
         if (c == 13) check("gap_valid_early", resValid, 1'b0);
         if (c == 14) check("gap_valid", resValid, 1'b1);
      end
      check("gap_accepted", resValid, 1'b0);

      // Backpressure: held result, ignored start, then accept+start together.
      expect_res(16'hC000);
      do_start(5'd2);
      send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
      resReady = 1'b0;
      send(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         start = (k == 2); winLog = 5'd1; enable = 1'b1; bitIn = 1'b1;
         tick();
         check("bp_result", {16'h0, result}, 32'hC000);
         check("bp_valid",  resValid, 1'b1);
         check("bp_busy",   busy,     1'b0);
      end
      start = 1'b0;
      expect_res(16'h4000);
      resReady = 1'b1;
      do_start(5'd2);
      check("b2b_valid", resValid, 1'b0);
      check("b2b_busy",  busy,     1'b1);
      send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
      check("b2b_done", resValid, 1'b1);
      enable = 1'b0;
      tick();

      // Restart mid-window discards earlier samples.
      expect_res(16'h4000);
      do_start(5'd4);
      for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
      do_start(5'd4);
      check("rs_valid", resValid, 1'b0);
      check("rs_busy",  busy,     1'b1);
      for (int i = 0; i < 16; i++) send(1'b1, pat(4, i));
      check("rs_done", resValid, 1'b1);
      enable = 1'b0;
      tick();

      // Asynchronous reset in the middle of a window.
      do_start(5'd4);
      send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
      rst_n = 1'b0;
      #2;
      check("arst_busy",   busy,     1'b0);
      check("arst_valid",  resValid, 1'b0);
      check("arst_result", {16'h0, result}, 32'h0);
      #1;
      rst_n = 1'b1;
      enable = 1'b0;
      tick();
      check("arst_idle", busy, 1'b0);
      expect_res(16'h8000);
      do_start(5'd1);
      send(1'b1, 1'b0); send(1'b1, 1'b1);
      check("arst_next_valid", resValid, 1'b1);
      enable = 1'b0;
      tick();

      // Loopback: first-dimension Sobol compared against operand 0xA000.
      expect_res(16'hA000);
      do_start(5'd4);
      s = 16'h0; cnt = 0; guard = 0;
      while (cnt < 16 && guard < 1000) begin
         guard++;
         if ($urandom_range(0, 1) == 1) begin
            send(1'b1, 4'hA > s[15:12]);
            tz = 0;
            while (((cnt + 1) >> tz) % 2 == 0) tz++;
            s = s ^ (16'h8000 >> tz);
            cnt++;
         end else begin
            send(1'b0, 1'($urandom_range(0, 1)));
         end
      end
      check("loop_count", cnt, 16);
      check("loop_valid", resValid, 1'b1);
      enable = 1'b0;
      tick();
      tick();

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("txn_count", n_seen, n_pushed);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/urate_bitstream_decoder.md
Name: urate_bitstream_decoder

Overview:
- Converts a rate-coded unary bitstream back to binary: counts ones over a window of 2^winLog enabled cycles and returns a WIDTH-bit fixed-point fraction.
- It is the receive end of the Sobol-driven unary-rate generators. Its output uses the same scale as the generator's binary operand: value/2^WIDTH equals the ones rate.
- Results are held behind a valid/ready handshake until consumed.

Parameters:
WIDTH, 16, output/fraction width; maximum window = 2^WIDTH bits
LOGWIDTH, 4, log2(WIDTH); winLog port is LOGWIDTH+1 bits

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous reset, active low
start  input  1  single-cycle pulse; captures winLog and begins a new window
winLog  input  LOGWIDTH+1  log2 of window length; legal 0..WIDTH, values >WIDTH clamp to WIDTH
enable  input  1  bit qualifier; bitIn is sampled only when high (same semantics as the generator's enable)
bitIn  input  1  unary bitstream
busy  output  1  high in RUN
resValid  output  1  result valid, held until accepted
resReady  input  1  consumer accepts result when high with resValid
result  output  WIDTH  decoded fraction

Behaviour:
- Reset (async, rst_n low) takes effect immediately, mid-operation included:
  - state=IDLE; busy=0, resValid=0, result=0.
  - Internal counters and captured winLog are cleared.
- Internal registers:
  - winQ (captured, clamped winLog).
  - bitCnt: WIDTH+1 bits, enabled samples taken.
  - onesCnt: WIDTH+1 bits, ones seen.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - On start: winQ<=clamp(winLog), bitCnt<=0, onesCnt<=0, go to RUN.
  - enable/bitIn are ignored in IDLE, including in the start cycle. Sampling begins the cycle after start.
- RUN (busy=1):
  - Each cycle with enable=1: bitCnt+=1, onesCnt+=bitIn.
  - Cycles with enable=0 change nothing.
  - Last sample: the edge on which bitCnt+1 == 2^winQ with enable=1. On that edge:
    - result <= sat(onesFinal << (WIDTH-winQ)), where onesFinal = onesCnt+bitIn.
    - resValid<=1, go to DONE.
  - resValid is therefore high in the cycle directly after the final sampled bit.
  - Saturation: a shifted value of 2^WIDTH (all ones in the window) becomes 2^WIDTH-1. No other overflow is possible.
  - start in RUN aborts the window and restarts it exactly as from IDLE, with winLog re-captured. resValid stays 0.
- DONE (busy=0, resValid=1):
  - result and resValid are stable while resReady=0.
  - resReady=1 and start=0: resValid<=0, go to IDLE. result keeps its last value.
  - resReady=1 and start=1: result is accepted and a new window starts (go to RUN) on the same edge.
  - start with resReady=0 is ignored.
  - enable/bitIn are ignored in DONE.
- winLog=0: the window is 1 sample; shift = WIDTH; bit 1 gives saturated 2^WIDTH-1.
- winLog changes after start have no effect until the next start.
- Only captured winQ is used after start. The counter width WIDTH+1 covers 2^WIDTH samples without wrap.

Test Plan:
1. Alternating pattern:
   - Stimulus: winLog=4, start, then 16 enabled bits 1,0,1,0,…
   - Response: resValid rises the cycle after the 16th sample; result=0x8000; busy low from that cycle.
2. Saturation and zero:
   - Stimulus: winLog=4, all 16 bits 1.
   - Response: result=0xFFFF.
   - Repeat with all bits 0: result=0x0000.
   - winLog=0 with a single 1: result=0xFFFF. winLog=20: clamps, window=65536 samples.
3. Enable gaps:
   - Stimulus: winLog=3; enable toggles every cycle; bitIn=1 on every disabled cycle; 6 of the 8 enabled bits are 1.
   - Response: result=0xC000 after the 8th enabled sample. Disabled-cycle bits are not counted.
4. Backpressure and back-to-back:
   - Stimulus: after DONE, hold resReady=0 for 5 cycles and pulse start during them.
   - Response: result and resValid are stable and start is ignored.
   - Then resReady=1 with start=1 in the same cycle: resValid drops next cycle, busy=1, and a fresh window counts from 0.
5. Restart and reset mid-run:
   - Stimulus: winLog=4, 5 samples of 1, start again, then 16 samples containing 4 ones.
   - Response: result=0x4000 (the first 5 samples are discarded).
   - Separately, assert rst_n low mid-RUN: busy/resValid/result go to 0 immediately. The next start decodes correctly.
6. Loopback against the generator:
   - Stimulus: compare operand 0xA000 with the top 4 bits of the 16-bit Sobol sequence to produce bitIn; winLog=4; both blocks share enable.
   - Response: result=0xA000 exactly.
